// File: rtl/note_track_scroller_if.sv
// Bus between the drum-game core and its surroundings: rate tick, run level,
// raw pads, pattern ROM lookup, and the track/score outputs to the display.
// master = environment (drives tick/run/pad/pat_data), slave = scroller core.
interface note_track_scroller_if #(
  parameter int LANES   = 4,
  parameter int DEPTH   = 16,
  parameter int PAT_LEN = 64
);
  logic                       tick;
  logic                       run;
  logic [LANES-1:0]           pad;
  logic [LANES-1:0]           pat_data;
  logic [$clog2(PAT_LEN)-1:0] pat_addr;
  logic [LANES*DEPTH-1:0]     track;
  logic [LANES-1:0]           hit;
  logic [15:0]                score;
  logic [7:0]                 combo;
  logic [7:0]                 misses;
  logic                       game_over;

  modport master (
    output tick, run, pad, pat_data,
    input  pat_addr, track, hit, score, combo, misses, game_over
  );

  modport slave (
    input  tick, run, pad, pat_data,
    output pat_addr, track, hit, score, combo, misses, game_over
  );
endinterface

// File: rtl/note_track_scroller.sv
// Drum-game core: scrolls note columns down LANES lanes on each tick, loads
// row 0 from the pattern ROM, judges pad strikes in the bottom two rows, and
// keeps score/combo/miss counters. Ports: clk, rst_n, bus (slave modport).
module note_track_scroller #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 16,
  parameter int PAT_LEN  = 64,
  parameter int MAX_MISS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  note_track_scroller_if.slave  bus
);
  localparam int AW = $clog2(PAT_LEN);
  localparam int TW = LANES * DEPTH;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t           state;
  logic [LANES-1:0] s1, s2, s3;
  logic [TW-1:0]    track_q;
  logic [AW-1:0]    pat_addr_q;
  logic [LANES-1:0] hit_q;
  logic [15:0]      score_q;
  logic [7:0]       combo_q;
  logic [7:0]       misses_q;
  logic             game_over_q;

  logic [LANES-1:0] strike;
  logic [LANES-1:0] hit_nxt;
  logic [TW-1:0]    post;      // track after strike clears, before scroll
  logic [TW-1:0]    shifted;   // post-clear track scrolled down one row
  logic [15:0]      score_add;
  logic [7:0]       hit_cnt;
  logic [7:0]       miss_cnt;
  logic             wrong;
  logic [16:0]      score_sum;
  logic [15:0]      score_nxt;
  logic [8:0]       combo_sum;
  logic [7:0]       combo_inc;
  logic [8:0]       misses_sum;
  logic [7:0]       misses_nxt;

  always_comb begin
    strike    = s2 & ~s3;
    post      = track_q;
    hit_nxt   = '0;
    score_add = '0;
    hit_cnt   = '0;
    miss_cnt  = '0;
    wrong     = 1'b0;
    shifted   = '0;

    // Judge on the pre-shift track; the bottom row takes precedence.
    for (int l = 0; l < LANES; l++) begin
      if (strike[l]) begin
        if (track_q[l*DEPTH + DEPTH-1]) begin
          post[l*DEPTH + DEPTH-1] = 1'b0;
          hit_nxt[l] = 1'b1;
          score_add  = score_add + 16'd2;
          hit_cnt    = hit_cnt + 8'd1;
        end else if (track_q[l*DEPTH + DEPTH-2]) begin
          post[l*DEPTH + DEPTH-2] = 1'b0;
          hit_nxt[l] = 1'b1;
          score_add  = score_add + 16'd1;
          hit_cnt    = hit_cnt + 8'd1;
        end else begin
          wrong = 1'b1;
        end
      end
    end

    // Scroll from the post-clear bitmap so a note hit this cycle is not missed.
    for (int l = 0; l < LANES; l++) begin
      miss_cnt = miss_cnt + {7'd0, post[l*DEPTH + DEPTH-1]};
      shifted[l*DEPTH +: DEPTH] = {post[l*DEPTH +: DEPTH-1], bus.pat_data[l]};
    end

    score_sum  = {1'b0, score_q} + {1'b0, score_add};
    score_nxt  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    combo_sum  = {1'b0, combo_q} + {1'b0, hit_cnt};
    combo_inc  = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    misses_sum = {1'b0, misses_q} + {1'b0, miss_cnt};
    misses_nxt = (misses_sum >= 9'(MAX_MISS)) ? 8'(MAX_MISS) : misses_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      track_q     <= '0;
      pat_addr_q  <= '0;
      hit_q       <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      // Pad synchronizer runs in every state so edges are never stale on entry.
      s1    <= bus.pad;
      s2    <= s1;
      s3    <= s2;
      hit_q <= '0;

      case (state)
        IDLE: begin
          if (bus.run) begin
            state      <= PLAY;
            track_q    <= '0;
            pat_addr_q <= '0;
            score_q    <= '0;
            combo_q    <= '0;
            misses_q   <= '0;
          end
        end

        PLAY: begin
          if (!bus.run) begin
            state <= IDLE;
          end else if (misses_q == 8'(MAX_MISS)) begin
            // Game ends here; nothing else moves from this edge on.
            state       <= OVER;
            game_over_q <= 1'b1;
          end else begin
            hit_q   <= hit_nxt;
            score_q <= score_nxt;
            combo_q <= wrong ? 8'd0 : combo_inc;
            if (bus.tick) begin
              track_q    <= shifted;
              pat_addr_q <= pat_addr_q + AW'(1);
              misses_q   <= misses_nxt;
              // A miss clears combo even if another lane hit this cycle.
              if (miss_cnt != 8'd0) combo_q <= 8'd0;
            end else begin
              track_q <= post;
            end
          end
        end

        OVER: begin
          if (!bus.run) begin
            state       <= IDLE;
            game_over_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.track     = track_q;
  assign bus.pat_addr  = pat_addr_q;
  assign bus.hit       = hit_q;
  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_note_track_scroller.sv
module tb_note_track_scroller;
  localparam int LANES    = 4;
  localparam int DEPTH    = 16;
  localparam int PAT_LEN  = 64;
  localparam int MAX_MISS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_track_scroller_if #(.LANES(LANES), .DEPTH(DEPTH), .PAT_LEN(PAT_LEN)) bus();

  note_track_scroller #(
    .LANES(LANES), .DEPTH(DEPTH), .PAT_LEN(PAT_LEN), .MAX_MISS(MAX_MISS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [3:0] rom [PAT_LEN];
  assign bus.pat_data = rom[bus.pat_addr];

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] e;
  string       t;
  int          pulses;

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  task automatic rom_fill(logic [3:0] v);
    for (int i = 0; i < PAT_LEN; i++) rom[i] = v;
  endtask

  task automatic start_game();
    bus.run = 1'b0;
    step(2);
    bus.run = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    exp_q.push_back(64'd0); tag_q.push_back("reset_track");
    exp_q.push_back(64'd0); tag_q.push_back("reset_counters");
    exp_q.push_back(64'd0); tag_q.push_back("reset_addr_flags");
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'({bus.score, bus.combo, bus.misses}) !== e) $display("FAIL %s: got %0h want %0h", t, {bus.score, bus.combo, bus.misses}, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'({bus.pat_addr, bus.hit, bus.game_over}) !== e) $display("FAIL %s: got %0h want %0h", t, {bus.pat_addr, bus.hit, bus.game_over}, e); else n_pass++;
  endtask

  task automatic test_scroll();
    rom_fill(4'h0); rom[0] = 4'b0001;
    start_game();
    exp_q.push_back(64'h8000); tag_q.push_back("scroll_track_t16");
    exp_q.push_back(64'd16);   tag_q.push_back("scroll_addr_t16");
    repeat (16) do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    exp_q.push_back(64'd1);  tag_q.push_back("scroll_miss_t17");
    exp_q.push_back(64'd17); tag_q.push_back("scroll_addr_t17");
    exp_q.push_back(64'd0);  tag_q.push_back("scroll_track_t17");
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
  endtask

  task automatic test_hit_row15();
    rom_fill(4'h0); rom[0] = 4'b0001;
    start_game();
    repeat (16) do_tick();
    exp_q.push_back(64'b0001); tag_q.push_back("hit15_pulse");
    exp_q.push_back(64'd2);    tag_q.push_back("hit15_score");
    exp_q.push_back(64'd1);    tag_q.push_back("hit15_combo");
    exp_q.push_back(64'd0);    tag_q.push_back("hit15_track_cleared");
    bus.pad[0] = 1'b1;
    step(3);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.hit) !== e) $display("FAIL %s: got %0b want %0b", t, bus.hit, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.combo) !== e) $display("FAIL %s: got %0d want %0d", t, bus.combo, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
    exp_q.push_back(64'd0); tag_q.push_back("hit15_pulse_end");
    step(1);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.hit) !== e) $display("FAIL %s: got %0b want %0b", t, bus.hit, e); else n_pass++;
    bus.pad = '0;
    step(3);
    exp_q.push_back(64'd0); tag_q.push_back("hit15_no_miss");
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
  endtask

  task automatic test_row14_and_wrong();
    rom_fill(4'h0); rom[0] = 4'b0001;
    start_game();
    repeat (15) do_tick();
    exp_q.push_back(64'd1); tag_q.push_back("row14_score");
    exp_q.push_back(64'd1); tag_q.push_back("row14_combo");
    bus.pad[0] = 1'b1;
    step(3);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.combo) !== e) $display("FAIL %s: got %0d want %0d", t, bus.combo, e); else n_pass++;
    bus.pad[0] = 1'b0;
    step(2);
    exp_q.push_back(64'd0); tag_q.push_back("wrong_combo");
    exp_q.push_back(64'd1); tag_q.push_back("wrong_score");
    bus.pad[1] = 1'b1;
    step(3);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.combo) !== e) $display("FAIL %s: got %0d want %0d", t, bus.combo, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    bus.pad = '0;
    step(3);
  endtask

  task automatic test_same_cycle();
    rom_fill(4'h0); rom[0] = 4'b0001;
    start_game();
    repeat (16) do_tick();
    exp_q.push_back(64'd2);    tag_q.push_back("same_score");
    exp_q.push_back(64'd0);    tag_q.push_back("same_misses");
    exp_q.push_back(64'b0001); tag_q.push_back("same_hit");
    exp_q.push_back(64'd17);   tag_q.push_back("same_addr");
    bus.pad[0] = 1'b1;
    step(2);
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.hit) !== e) $display("FAIL %s: got %0b want %0b", t, bus.hit, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    bus.pad = '0;
    step(3);
  endtask

  task automatic test_back_to_back_lanes();
    rom_fill(4'h0); rom[0] = 4'b1011;
    start_game();
    repeat (16) do_tick();
    exp_q.push_back(64'b1011); tag_q.push_back("multi_hit");
    exp_q.push_back(64'd6);    tag_q.push_back("multi_score");
    exp_q.push_back(64'd3);    tag_q.push_back("multi_combo");
    bus.pad = 4'b1011;
    step(3);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.hit) !== e) $display("FAIL %s: got %0b want %0b", t, bus.hit, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.combo) !== e) $display("FAIL %s: got %0d want %0d", t, bus.combo, e); else n_pass++;
    bus.pad = '0;
    step(3);
  endtask

  task automatic test_hold_and_restart();
    rom_fill(4'h0); rom[0] = 4'b0100; rom[1] = 4'b0100;
    start_game();
    repeat (16) do_tick();
    // Two stacked notes in lane 2: a retrigger would also take the row-14 one.
    exp_q.push_back(64'd1); tag_q.push_back("hold_pulses");
    exp_q.push_back(64'd2); tag_q.push_back("hold_score");
    exp_q.push_back(64'd1); tag_q.push_back("hold_row14_kept");
    bus.pad[2] = 1'b1;
    pulses = 0;
    repeat (50) begin
      step(1);
      if (bus.hit[2]) pulses++;
    end
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(pulses) !== e) $display("FAIL %s: got %0d want %0d", t, pulses, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.track[2*DEPTH + DEPTH-2]) !== e) $display("FAIL %s: got %0b want %0b", t, bus.track[2*DEPTH + DEPTH-2], e); else n_pass++;
    bus.pad = '0;
    step(3);
    do_tick();
    exp_q.push_back(64'd2);  tag_q.push_back("idle_score_held");
    exp_q.push_back(64'd17); tag_q.push_back("idle_addr_held");
    bus.run = 1'b0;
    step(1);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    exp_q.push_back(64'd0); tag_q.push_back("restart_counters");
    exp_q.push_back(64'd0); tag_q.push_back("restart_addr");
    exp_q.push_back(64'd0); tag_q.push_back("restart_track");
    bus.run = 1'b1;
    step(1);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'({bus.score, bus.combo, bus.misses}) !== e) $display("FAIL %s: got %0h want %0h", t, {bus.score, bus.combo, bus.misses}, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
  endtask

  task automatic test_saturate_over();
    rom_fill(4'hF);
    start_game();
    repeat (16) do_tick();
    exp_q.push_back(64'd4);  tag_q.push_back("sat_miss_t17");
    exp_q.push_back(64'd8);  tag_q.push_back("sat_miss_t18");
    exp_q.push_back(64'd10); tag_q.push_back("sat_miss_t19");
    exp_q.push_back(64'd0);  tag_q.push_back("sat_over_not_yet");
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    do_tick();
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.game_over) !== e) $display("FAIL %s: got %0b want %0b", t, bus.game_over, e); else n_pass++;
    exp_q.push_back(64'd1); tag_q.push_back("sat_game_over");
    step(1);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.game_over) !== e) $display("FAIL %s: got %0b want %0b", t, bus.game_over, e); else n_pass++;
    exp_q.push_back(64'd19);                  tag_q.push_back("over_addr_frozen");
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); tag_q.push_back("over_track_frozen");
    exp_q.push_back(64'd10);                  tag_q.push_back("over_misses_frozen");
    exp_q.push_back(64'd0);                   tag_q.push_back("over_strike_ignored");
    repeat (3) do_tick();
    bus.pad = 4'hF;
    step(4);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.pat_addr) !== e) $display("FAIL %s: got %0d want %0d", t, bus.pat_addr, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (bus.track !== e) $display("FAIL %s: got %0h want %0h", t, bus.track, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.misses) !== e) $display("FAIL %s: got %0d want %0d", t, bus.misses, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.score) !== e) $display("FAIL %s: got %0d want %0d", t, bus.score, e); else n_pass++;
    bus.pad = '0;
    exp_q.push_back(64'd0); tag_q.push_back("over_exit_idle");
    bus.run = 1'b0;
    step(1);
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'(bus.game_over) !== e) $display("FAIL %s: got %0b want %0b", t, bus.game_over, e); else n_pass++;
  endtask

  task automatic test_reset_mid_game();
    rom_fill(4'h0); rom[0] = 4'b0001;
    start_game();
    repeat (16) do_tick();
    bus.pad[0] = 1'b1;
    step(3);
    exp_q.push_back(64'd0); tag_q.push_back("arst_counters");
    exp_q.push_back(64'd0); tag_q.push_back("arst_addr_hit");
    // Reset lands between clock edges; the clear must not wait for an edge.
    #3;
    rst_n = 1'b0;
    #1;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'({bus.score, bus.combo, bus.misses}) !== e) $display("FAIL %s: got %0h want %0h", t, {bus.score, bus.combo, bus.misses}, e); else n_pass++;
    e = exp_q.pop_front(); t = tag_q.pop_front(); n_checks++;
    if (64'({bus.pat_addr, bus.hit}) !== e) $display("FAIL %s: got %0h want %0h", t, {bus.pat_addr, bus.hit}, e); else n_pass++;
    bus.pad = '0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.run  = 1'b0;
    bus.pad  = '0;
    rom_fill(4'h0);
    rst_n = 1'b0;
    step(2);
    test_reset();
    rst_n = 1'b1;
    step(1);
    test_scroll();
    test_hit_row15();
    test_row14_and_wrong();
    test_same_cycle();
    test_back_to_back_lanes();
    test_hold_and_restart();
    test_saturate_over();
    test_reset_mid_game();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
